// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write / status bundle for the program loader.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 7
);
  logic              Byte_Valid;
  logic [7:0]        Byte_Data;
  logic              Byte_Ready;
  logic              IM_WE;
  logic [ADDR_W-1:0] IM_WA;
  logic [31:0]       IM_WD;
  logic              CPU_Hold;
  logic              Load_Done;
  logic              Load_Err;

  modport master (
    output Byte_Valid, Byte_Data,
    input  Byte_Ready, IM_WE, IM_WA, IM_WD, CPU_Hold, Load_Done, Load_Err
  );

  modport slave (
    input  Byte_Valid, Byte_Data,
    output Byte_Ready, IM_WE, IM_WA, IM_WD, CPU_Hold, Load_Done, Load_Err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Framed serial program loader: A5, count lo/hi, 4*N little-endian payload bytes, XOR checksum.
// States: IDLE (wait for A5), CNT_LO/CNT_HI (word count), DATA (payload), CSUM (compare).
module instr_mem_loader #(
  parameter int DEPTH         = 128,
  parameter int ADDR_W        = 7,
  parameter bit HOLD_AT_RESET = 1'b0
) (
  input logic            CLK,
  input logic            RESETn,
  instr_mem_loader_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM} state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  logic              accept;
  logic [15:0]       n_cnt;
  logic [15:0]       word_nxt;

  assign accept   = bus.Byte_Valid && ready_q;
  assign n_cnt    = {bus.Byte_Data, cnt_q[7:0]};
  assign word_nxt = 16'(word_cnt_q) + 16'd1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= HOLD_AT_RESET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    ready_d    = 1'b1;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    done_d     = done_q;
    err_d      = err_q;
    hold_d     = hold_q;

    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.Byte_Data == 8'hA5) begin
            state_d    = S_CNT_LO;
            done_d     = 1'b0;
            err_d      = 1'b0;
            hold_d     = 1'b1;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
          end
        end
        S_CNT_LO: begin
          cnt_d[7:0] = bus.Byte_Data;
          state_d    = S_CNT_HI;
        end
        S_CNT_HI: begin
          cnt_d = n_cnt;
          if (n_cnt > 16'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (n_cnt == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d     = csum_q ^ bus.Byte_Data;
          asm_d      = {bus.Byte_Data, asm_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes the word: first byte lands in bits [7:0].
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            wa_d       = word_cnt_q[ADDR_W-1:0];
            wd_d       = {bus.Byte_Data, asm_q};
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_nxt == cnt_q) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (bus.Byte_Data == csum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.Byte_Ready = ready_q;
  assign bus.IM_WE      = we_q;
  assign bus.IM_WA      = wa_q;
  assign bus.IM_WD      = wd_q;
  assign bus.CPU_Hold   = hold_q;
  assign bus.Load_Done  = done_q;
  assign bus.Load_Err   = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: frame parsing, write pulses, status flags, reset abort.
module tb_instr_mem_loader;
  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instr_mem_loader_if #(.ADDR_W(7)) bus ();
  instr_mem_loader #(.DEPTH(128), .ADDR_W(7), .HOLD_AT_RESET(1'b0)) dut (
    .CLK(CLK), .RESETn(RESETn), .bus(bus)
  );

  always #5 CLK = ~CLK;

  logic [6:0]  log_wa[$];
  logic [31:0] log_wd[$];
  int          wr_count = 0;
  int          we_long  = 0;
  logic        we_prev  = 1'b0;

  always @(negedge CLK) begin
    if (bus.IM_WE === 1'b1) begin
      log_wa.push_back(bus.IM_WA);
      log_wd.push_back(bus.IM_WD);
      wr_count++;
      if (we_prev) we_long++;
    end
    we_prev = (bus.IM_WE === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.Byte_Valid = 1'b1;
    bus.Byte_Data  = b;
    @(posedge CLK); #1;
    bus.Byte_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Two-word frame; checksum byte is the XOR of the eight payload bytes (0xFB).
  task automatic send_good2(input logic [7:0] csum);
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'hFC); send(8'h11); send(8'h9F); send(8'hE5);
    send(8'h04); send(8'h12); send(8'h9F); send(8'hE5);
    send(csum);
  endtask

  int          base;
  logic [7:0]  k8;
  logic [7:0]  xs;

  initial begin
    bus.Byte_Valid = 1'b0;
    bus.Byte_Data  = 8'h00;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_ready", bus.Byte_Ready, 0);
    check("rst_we",    bus.IM_WE, 0);
    check("rst_wa",    bus.IM_WA, 0);
    check("rst_wd",    bus.IM_WD, 0);
    check("rst_done",  bus.Load_Done, 0);
    check("rst_err",   bus.Load_Err, 0);
    check("rst_hold",  bus.CPU_Hold, 0);
    RESETn = 1'b1;
    #1 check("ready_before_edge", bus.Byte_Ready, 0);
    @(posedge CLK); #1;
    check("ready_after_edge", bus.Byte_Ready, 1);

    // Good two-word load
    base = wr_count;
    send(8'hA5);
    check("hold_after_a5", bus.CPU_Hold, 1);
    send(8'h02); send(8'h00);
    send(8'hFC); send(8'h11); send(8'h9F); send(8'hE5);
    check("we_pulse_w0", bus.IM_WE, 1);
    send(8'h04);
    check("we_low_after", bus.IM_WE, 0);
    check("wa_hold", bus.IM_WA, 0);
    send(8'h12); send(8'h9F); send(8'hE5);
    send(8'hFB);
    check("good_writes", wr_count - base, 2);
    check("good_wa0", log_wa[base], 0);
    check("good_wd0", log_wd[base], 32'hE59F11FC);
    check("good_wa1", log_wa[base+1], 1);
    check("good_wd1", log_wd[base+1], 32'hE59F1204);
    check("good_done", bus.Load_Done, 1);
    check("good_err",  bus.Load_Err, 0);
    check("good_hold", bus.CPU_Hold, 0);

    // Bad checksum, then recovery
    base = wr_count;
    send_good2(8'h00);
    check("bad_writes", wr_count - base, 2);
    check("bad_err",  bus.Load_Err, 1);
    check("bad_done", bus.Load_Done, 0);
    check("bad_hold", bus.CPU_Hold, 1);
    send_good2(8'hFB);
    check("recover_err",  bus.Load_Err, 0);
    check("recover_done", bus.Load_Done, 1);
    check("recover_hold", bus.CPU_Hold, 0);

    // Oversize frame
    base = wr_count;
    send(8'hA5); send(8'h81); send(8'h00);
    check("over_err",  bus.Load_Err, 1);
    check("over_done", bus.Load_Done, 0);
    check("over_hold", bus.CPU_Hold, 1);
    idle(3);
    check("over_writes", wr_count - base, 0);

    // Empty frame
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    check("empty_done", bus.Load_Done, 1);
    check("empty_hold", bus.CPU_Hold, 0);
    check("empty_writes", wr_count - base, 0);

    // Junk before start, gaps inside payload
    base = wr_count;
    send(8'h00); send(8'hFF); send(8'h3C);
    check("junk_done_kept", bus.Load_Done, 1);
    send(8'hA5); idle(2); send(8'h01); send(8'h00);
    send(8'h78); idle(3); send(8'h56); idle(1); send(8'h34); idle(5); send(8'h12);
    idle(2); send(8'h08);
    check("gap_writes", wr_count - base, 1);
    check("gap_wd", log_wd[base], 32'h12345678);
    check("gap_done", bus.Load_Done, 1);

    // A5 inside count/payload is plain data
    base = wr_count;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hA5); send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
    check("a5_data_wd", log_wd[base], 32'h0201A5A5);
    check("a5_data_done", bus.Load_Done, 1);

    // Full-depth frame
    base = wr_count;
    xs = 8'h00;
    send(8'hA5); send(8'h80); send(8'h00);
    for (int k = 0; k < 128; k++) begin
      k8 = 8'(k);
      send(~k8); send(k8 ^ 8'h5A); send(8'hC3); send(k8);
      xs = xs ^ (~k8) ^ (k8 ^ 8'h5A) ^ 8'hC3 ^ k8;
    end
    send(xs);
    check("full_writes", wr_count - base, 128);
    check("full_first_wd", log_wd[base], 32'h00C35AFF);
    check("full_last_wa", log_wa[base+127], 7'd127);
    check("full_last_wd", log_wd[base+127], 32'h7FC32580);
    check("full_done", bus.Load_Done, 1);

    // Reset mid-frame
    base = wr_count;
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    @(negedge CLK);
    RESETn = 1'b0;
    #2;
    check("abort_hold", bus.CPU_Hold, 0);
    check("abort_ready", bus.Byte_Ready, 0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK); #1;
    check("abort_writes", wr_count - base, 1);
    check("abort_wd", log_wd[base], 32'h44332211);
    base = wr_count;
    send_good2(8'hFB);
    check("after_abort_writes", wr_count - base, 2);
    check("after_abort_wd1", log_wd[base+1], 32'hE59F1204);
    check("after_abort_done", bus.Load_Done, 1);
    check("we_single_cycle", we_long, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
